// File: rtl/cpu_jtag_debug_cmd_bridge.sv
// System-clock side of the CPU JTAG debug bridge: synchronises the update strobes,
// queues {ir, sr} captures in a small FIFO and issues per-IR action pulses on pop.
module cpu_jtag_debug_cmd_bridge #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int ACT_BIT     = 35,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  localparam int N          = 2**IR_W,
  localparam int LVL_W      = $clog2(FIFO_DEPTH+1),
  localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sr,
  input  logic [IR_W-1:0]   ir_in,
  input  logic              vs_udr,
  input  logic              vs_uir,
  input  logic              cmd_ready,
  input  logic              clear_ovf,
  output logic              cmd_valid,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [DATA_W-1:0] jdo,
  output logic [N-1:0]      take_action,
  output logic [N-1:0]      take_no_action,
  output logic              ir_update,
  output logic              overflow,
  output logic [LVL_W-1:0]  fifo_level
);

  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic                   r_udr_dly;
  logic                   r_uir_dly;

  logic [DATA_W-1:0]      r_mem_data [FIFO_DEPTH];
  logic [IR_W-1:0]        r_mem_ir   [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [LVL_W-1:0]       r_count;

  logic [DATA_W-1:0]      r_jdo;
  logic [N-1:0]           r_take_action;
  logic [N-1:0]           r_take_no_action;
  logic                   r_ir_update;
  logic                   r_overflow;

  logic                   w_udr_pulse;
  logic                   w_uir_pulse;
  logic                   w_valid;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [DATA_W-1:0]      w_head_data;
  logic [IR_W-1:0]        w_head_ir;
  logic [N-1:0]           w_head_onehot;

  // Delay flops reset to 0, so a strobe already high at reset release reads as a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_udr_sync <= '0;
      r_uir_sync <= '0;
      r_udr_dly  <= 1'b0;
      r_uir_dly  <= 1'b0;
    end else begin
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_dly  <= r_udr_sync[SYNC_STAGES-1];
      r_uir_dly  <= r_uir_sync[SYNC_STAGES-1];
    end
  end

  assign w_udr_pulse = r_udr_sync[SYNC_STAGES-1] & ~r_udr_dly;
  assign w_uir_pulse = r_uir_sync[SYNC_STAGES-1] & ~r_uir_dly;

  assign w_valid       = (r_count != '0);
  assign w_full        = (r_count == LVL_W'(FIFO_DEPTH));
  assign w_pop         = w_valid & cmd_ready;
  // A full FIFO still accepts a capture when the head leaves on the same edge.
  assign w_push        = w_udr_pulse & (~w_full | w_pop);
  assign w_drop        = w_udr_pulse & w_full & ~w_pop;
  assign w_head_data   = r_mem_data[r_rptr];
  assign w_head_ir     = r_mem_ir[r_rptr];
  assign w_head_onehot = {{(N-1){1'b0}}, 1'b1} << w_head_ir;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= sr;
      r_mem_ir[r_wptr]   <= ir_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jdo            <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
      r_ir_update      <= 1'b0;
      r_overflow       <= 1'b0;
    end else begin
      r_take_action    <= '0;
      r_take_no_action <= '0;
      r_ir_update      <= w_uir_pulse;
      if (w_pop) begin
        r_jdo <= w_head_data;
        if (w_head_data[ACT_BIT]) r_take_action    <= w_head_onehot;
        else                      r_take_no_action <= w_head_onehot;
      end
      if (w_drop)         r_overflow <= 1'b1;
      else if (clear_ovf) r_overflow <= 1'b0;
    end
  end

  assign cmd_valid      = w_valid;
  assign cmd_ir         = w_valid ? w_head_ir : '0;
  assign jdo            = r_jdo;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign ir_update      = r_ir_update;
  assign overflow       = r_overflow;
  assign fifo_level     = r_count;

endmodule
